checked_add_ctrl: RTL

CHECKED_ADD_CTRL -- requirements
Module: checked_add_ctrl

---
 rtl/checked_add_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/checked_add_ctrl.sv
// Checked-add controller: drives a dual-rail duplicated adder, waits for it
// to settle, verifies true/complement rails and retries on mismatch.
module checked_add_ctrl #(
  parameter int WIDTH     = 64,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_pa,
  output logic             add_pb,
  input  logic [WIDTH-1:0] add_s,
  input  logic [WIDTH-1:0] add_s_inv,
  input  logic             add_papb,
  input  logic             add_pab,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_err,
  output logic [2:0]       out_retries,
  output logic [1:0]       out_par,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {
    IDLE, WAIT, CHECK, DONE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [2:0]       retry_q, retry_d;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic             pa_d, pb_d, err_d;
  logic [2:0]       ret_d;
  logic [1:0]       par_d;
  logic [15:0]      ecnt_d;
  logic             pass;

  assign pass      = (add_s == ~add_s_inv);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    a_d      = add_a;
    b_d      = add_b;
    pa_d     = add_pa;
    pb_d     = add_pb;
    sum_d    = out_sum;
    err_d    = out_err;
    ret_d    = out_retries;
    par_d    = out_par;
    ecnt_d   = err_count;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          pa_d     = ^in_a;
          pb_d     = ^in_b;
          settle_d = SETTLE_INIT;
          retry_d  = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (settle_q == '0) state_d = CHECK;
        else settle_d = settle_q - 4'd1;
      end
      CHECK: begin
        if (pass || retry_q == RETRY_MAX) begin
          sum_d   = add_s;
          err_d   = !pass;
          ret_d   = retry_q;
          par_d   = {add_papb, add_pab};
          state_d = DONE;
          // saturate rather than wrap
          if (!pass && err_count != 16'hFFFF)
            ecnt_d = err_count + 16'd1;
        end else begin
          retry_d  = retry_q + 3'd1;
          settle_d = SETTLE_INIT;
          state_d  = WAIT;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      retry_q     <= '0;
      add_a       <= '0;
      add_b       <= '0;
      add_pa      <= 1'b0;
      add_pb      <= 1'b0;
      out_sum     <= '0;
      out_err     <= 1'b0;
      out_retries <= '0;
      out_par     <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      retry_q     <= retry_d;
      add_a       <= a_d;
      add_b       <= b_d;
      add_pa      <= pa_d;
      add_pb      <= pb_d;
      out_sum     <= sum_d;
      out_err     <= err_d;
      out_retries <= ret_d;
      out_par     <= par_d;
      err_count   <= ecnt_d;
    end
  end

endmodule
